fw_region_ctrl: RTL
===================

FW_REGION_CTRL -- requirements
Module: fw_region_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: address width of region registers and transactions.
REQ-002 Parameter NUM_REGIONS, default 4: number of programmable protected regions; IDX_W = $clog2(NUM_REGIONS).
REQ-003 Parameter REQUIRED_PRIV, default 2: minimum cfg_priv for config writes and lock.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 cfg_wr_en  input  1  config write strobe, one cycle per write.
REQ-007 cfg_idx  input  IDX_W  region index being written.
REQ-008 cfg_base / cfg_size  input  ADDR_WIDTH each  region base and byte size; size 0 disables the region.
REQ-009 cfg_priv  input  2  privilege of the config or lock requester.
REQ-010 lock_req  input  1  request to lock the region table.
REQ-011 cfg_err  output  1  one-cycle pulse: config write or lock rejected.
REQ-012 locked  output  1  region table is locked.
REQ-013 txn_valid / txn_ready  input / output  1 each  transaction handshake.
REQ-014 txn_addr  input  ADDR_WIDTH; txn_auth  input  1  master authorized.
REQ-015 dec_valid / dec_ready  output / input  1 each  decision handshake.
REQ-016 dec_blocked  output  1; dec_hit  output  1; dec_region  output  IDX_W.
REQ-017 viol_cnt  output  16  blocked-decision count (see Configuration).

Function
REQ-018 Config write accepted iff cfg_wr_en, !locked, cfg_priv >= REQUIRED_PRIV, cfg_idx < NUM_REGIONS; region updated at the next edge.
REQ-019 Rejected config write: region table unchanged; cfg_err high the next cycle.
REQ-020 lock_req with cfg_priv >= REQUIRED_PRIV: locked = 1 the next cycle; sticky until rst_n.
REQ-021 Insufficient-privilege lock_req, or any lock_req while locked: cfg_err pulse; locked unchanged.
REQ-022 Same-cycle accepted write and lock: write applied, then locked = 1.
REQ-023 Region match: enabled and base <= addr <= base+size-1.
- Computed at ADDR_WIDTH+1 bits; no wrap-around.
- base+size beyond 2^ADDR_WIDTH clips to the top of the address space.
REQ-024 Overlapping matches: lowest index wins for dec_region; dec_hit = any match.
REQ-025 dec_blocked = dec_hit && !txn_auth; no match gives dec_blocked = 0, dec_region = 0.
REQ-026 One-entry output register: txn_ready = (!dec_valid || dec_ready) && !cfg_wr_en.
- Transaction accepted on txn_valid && txn_ready.
- Decision presented with dec_valid the next cycle (latency 1).
REQ-027 dec_valid, dec_blocked, dec_hit, dec_region hold stable while dec_valid && !dec_ready.
REQ-028 Accept and drain in the same cycle: new decision loaded with no bubble; full throughput when dec_ready = 1.
REQ-029 Decisions use the region table as registered at the accept edge; a write lands no earlier than the following accept.

Reset
REQ-030 rst_n low: all regions cleared (base 0, size 0).
- locked = 0, cfg_err = 0, dec_valid = 0, dec_blocked = 0, dec_hit = 0, dec_region = 0, viol_cnt = 0.
REQ-031 Reset mid-operation: the pending decision is discarded with no dec_valid pulse; txn_ready = 1 in the first cycle after release.

Configuration
REQ-032 FW_VIOLATION_CNT_EN defined: viol_cnt increments on each dec_valid && dec_ready && dec_blocked, saturating at 16'hFFFF.
REQ-033 FW_VIOLATION_CNT_EN undefined: viol_cnt tied to 0, no counter flops; all other behaviour identical.

Structure
REQ-034 Package fw_pkg holds:
- region_t struct (base, size).
- Privilege-level constants.
- Decision struct (blocked, hit, region).
REQ-035 Sub-module fw_region_match: single-region combinational comparator, instantiated NUM_REGIONS times.

Verification
REQ-036 Write idx 1, base 32'h1000, size 32'h100, priv 2; txn addr 32'h10FF, auth 0 -> next cycle dec_valid, dec_blocked = 1, dec_region = 1; addr 32'h1100 -> dec_hit = 0, dec_blocked = 0.
REQ-037 Write with priv 1 -> cfg_err pulse, region unchanged; lock_req priv 3, then write priv 3 -> cfg_err, table unchanged, locked = 1.
REQ-038 Region 0 base 32'hFFFF_FF00, size 32'h200 -> addr 32'hFFFF_FFFF blocked, addr 32'h0000_0010 not matched (no wrap).
REQ-039 Regions 0 and 2 overlapping at 32'h2000 -> dec_region = 0; hold dec_ready = 0 for 3 cycles -> outputs stable, txn_ready = 0.
REQ-040 rst_n low mid-decision -> dec_valid = 0, locked = 0, all regions cleared; with FW_VIOLATION_CNT_EN, 3 blocked drains -> viol_cnt = 3.

Source files
------------

// File: rtl/fw_pkg.sv
// Shared types and constants for the firewall region controller.
// Latency: none; this file holds types only.
// Backpressure: none; this file holds types only.
package fw_pkg;

  // Widest address and index the shared structs can carry. Narrower
  // instances zero-extend into them.
  localparam int FW_MAX_ADDR_W = 64;
  localparam int FW_MAX_IDX_W  = 8;

  // Requester privilege levels, lowest to highest.
  typedef enum logic [1:0] {
    PRIV_USER    = 2'd0,
    PRIV_SUPER   = 2'd1,
    PRIV_MACHINE = 2'd2,
    PRIV_DEBUG   = 2'd3
  } priv_e;

  // One protected region. A size of 0 disables it.
  typedef struct packed {
    logic [FW_MAX_ADDR_W-1:0] base;
    logic [FW_MAX_ADDR_W-1:0] size;
  } region_t;

  // Per-transaction firewall decision.
  typedef struct packed {
    logic                    blocked;
    logic                    hit;
    logic [FW_MAX_IDX_W-1:0] region;
  } dec_t;

endpackage

// File: rtl/fw_region_match.sv
// Single-region address comparator: flags addr inside [base, base+size-1].
// Latency: combinational.
// Backpressure: none.
module fw_region_match
  import fw_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  region_t                 region,
  input  logic [ADDR_WIDTH-1:0]   addr,
  output logic                    match
);

  // The compare runs one bit wider than the stored fields, so base+size
  // never wraps. A region reaching past the top of the address space then
  // simply covers everything up to the highest address.
  logic [FW_MAX_ADDR_W:0] base_x;
  logic [FW_MAX_ADDR_W:0] end_x;
  logic [FW_MAX_ADDR_W:0] addr_x;

  assign base_x = {1'b0, region.base};
  assign end_x  = base_x + {1'b0, region.size};
  assign addr_x = {1'b0, FW_MAX_ADDR_W'(addr)};

  assign match = (region.size != '0) && (addr_x >= base_x) && (addr_x < end_x);

endmodule

// File: rtl/fw_region_ctrl.sv
// Region firewall: a privileged, lockable region table that classifies each transaction.
// Latency: 1 cycle from txn accept to dec_valid; back-to-back accepts give full throughput.
// Backpressure: one-entry decision register; txn_ready drops while a decision stalls or a config write is active.
// Optional feature: FW_VIOLATION_CNT_EN adds a saturating counter of blocked decisions.
module fw_region_ctrl
  import fw_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int NUM_REGIONS   = 4,
  parameter int REQUIRED_PRIV = int'(PRIV_MACHINE),
  localparam int IDX_W        = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_wr_en,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH-1:0] cfg_size,
  input  logic [1:0]            cfg_priv,
  input  logic                  lock_req,
  output logic                  cfg_err,
  output logic                  locked,
  input  logic                  txn_valid,
  output logic                  txn_ready,
  input  logic [ADDR_WIDTH-1:0] txn_addr,
  input  logic                  txn_auth,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic                  dec_blocked,
  output logic                  dec_hit,
  output logic [IDX_W-1:0]      dec_region,
  output logic [15:0]           viol_cnt
);

  region_t          regions_q [NUM_REGIONS];
  logic             locked_q;
  logic             cfg_err_q;
  logic             dec_valid_q;
  dec_t             dec_q;
  dec_t             lookup;
  logic [NUM_REGIONS-1:0] match_vec;

  logic priv_ok, idx_ok, wr_ok, lock_ok, txn_acc;

  assign priv_ok = 32'(cfg_priv) >= 32'(REQUIRED_PRIV);
  assign idx_ok  = 32'(cfg_idx) < 32'(NUM_REGIONS);
  assign wr_ok   = cfg_wr_en && !locked_q && priv_ok && idx_ok;
  assign lock_ok = lock_req && !locked_q && priv_ok;

  // Region table: accepted writes land at the next edge, reset clears all regions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGIONS; i++) regions_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (wr_ok && (cfg_idx == IDX_W'(i))) begin
          regions_q[i].base <= FW_MAX_ADDR_W'(cfg_base);
          regions_q[i].size <= FW_MAX_ADDR_W'(cfg_size);
        end
      end
    end
  end

  // Lock is sticky until reset. Any rejected write or lock raises a one-cycle error.
  // A write accepted in the same cycle as a lock still lands, because wr_ok
  // sees the pre-lock state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_q  <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      locked_q  <= locked_q | lock_ok;
      cfg_err_q <= (cfg_wr_en && !wr_ok) || (lock_req && !lock_ok);
    end
  end

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_match
    fw_region_match #(.ADDR_WIDTH(ADDR_WIDTH)) u_match (
      .region (regions_q[g]),
      .addr   (txn_addr),
      .match  (match_vec[g])
    );
  end

  // Priority select: scanning from the top index down leaves the lowest match in place.
  always_comb begin
    lookup = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        lookup.hit    = 1'b1;
        lookup.region = FW_MAX_IDX_W'(i);
      end
    end
    lookup.blocked = lookup.hit && !txn_auth;
  end

  // Holding off transactions during a config write means every decision
  // sees a settled table.
  assign txn_ready = (!dec_valid_q || dec_ready) && !cfg_wr_en;
  assign txn_acc   = txn_valid && txn_ready;

  // One-entry decision register: load on accept, clear on drain, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_valid_q <= 1'b0;
      dec_q       <= '0;
    end else if (txn_acc) begin
      dec_valid_q <= 1'b1;
      dec_q       <= lookup;
    end else if (dec_ready) begin
      dec_valid_q <= 1'b0;
    end
  end

`ifdef FW_VIOLATION_CNT_EN
  logic [15:0] viol_q;

  // Count blocked decisions as they drain; hold at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      viol_q <= 16'd0;
    end else if (dec_valid_q && dec_ready && dec_q.blocked && (viol_q != 16'hFFFF)) begin
      viol_q <= viol_q + 16'd1;
    end
  end

  assign viol_cnt = viol_q;
`else
  assign viol_cnt = 16'd0;
`endif

  assign cfg_err     = cfg_err_q;
  assign locked      = locked_q;
  assign dec_valid   = dec_valid_q;
  assign dec_blocked = dec_q.blocked;
  assign dec_hit     = dec_q.hit;
  assign dec_region  = IDX_W'(dec_q.region);

endmodule
